// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the seq_gen pattern serializer.
package seq_gen_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter holding the number of bits still to send after the
// one currently on the output; zero_o marks the last bit.
module seq_gen_cnt
    import seq_gen_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [LEN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// MSB-first pattern serializer with start/abort control and registered outputs.
// Optional repeat mode (rpt port) is enabled by defining SEQ_GEN_REPEAT_EN.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic               abort,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic               rpt,
`endif
    output logic               req,
    output logic               req_vld,
    output logic               busy,
    output logic               done,
    output state_t             state_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic               req_q, req_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [LEN_W-1:0]   cnt_val;
    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] pat_aligned;

    // Left-justify the pattern so the first bit to send always sits at the MSB.
    assign len_eff     = (len > MAX_LEN_L) ? MAX_LEN_L : len;
    assign pat_aligned = pat << (MAX_LEN_L - len_eff);

`ifdef SEQ_GEN_REPEAT_EN
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        req_d    = 1'b0;
        vld_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = len_eff - LEN_W'(1);
`ifdef SEQ_GEN_REPEAT_EN
        pat_d    = pat_q;
        len_d    = len_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_eff == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SHIFT;
                        cnt_load = 1'b1;
                        req_d    = pat_aligned[MAX_LEN-1];
                        shift_d  = pat_aligned << 1;
                        vld_d    = 1'b1;
                        busy_d   = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
                        pat_d    = pat_aligned;
                        len_d    = len_eff;
`endif
                    end
                end
            end
            SHIFT: begin
                // Abort wins over both the next bit and the last-bit exit.
                if (abort) begin
                    state_d = IDLE;
                    shift_d = '0;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                    req_d   = shift_q[MAX_LEN-1];
                    shift_d = shift_q << 1;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
                end else if (rpt) begin
                    cnt_load = 1'b1;
                    cnt_val  = len_q - LEN_W'(1);
                    req_d    = pat_q[MAX_LEN-1];
                    shift_d  = pat_q << 1;
                    vld_d    = 1'b1;
                    busy_d   = 1'b1;
`endif
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SEQ_GEN_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
        end
    end
`endif

    seq_gen_cnt #(
        .LEN_W(LEN_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    assign req     = req_q;
    assign req_vld = vld_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule
